isp_pattern_gen: RTL and testbench

//  Test-pattern video source for the ISP chain. Drives the href/vsync/RGB pixel

---
 rtl/isp_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_isp_pattern_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/isp_pattern_gen.sv
// Test-pattern video source: counter-driven frame timing with colour bars,
// gradient, solid colour and a moving ramp on a registered href/vsync/RGB stream.
module isp_pattern_gen #(
  parameter int BITS      = 8,
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 960,
  parameter int HBLANK    = 160,
  parameter int VS_LINES  = 2,
  parameter int VBP_LINES = 20,
  parameter int VFP_LINES = 5
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      pattern_sel,
  input  logic [BITS-1:0] solid_r,
  input  logic [BITS-1:0] solid_g,
  input  logic [BITS-1:0] solid_b,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_r,
  output logic [BITS-1:0] out_g,
  output logic [BITS-1:0] out_b,
  output logic            frame_done
);

  localparam int LINE_LEN  = WIDTH + HBLANK;
  localparam int HW        = $clog2(LINE_LEN);
  localparam int MAX_A     = (HEIGHT > VS_LINES) ? HEIGHT : VS_LINES;
  localparam int MAX_B     = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LW        = $clog2(MAX_LINES + 1);
  localparam int BAR_W     = WIDTH / 8;
  localparam int BPW       = $clog2(BAR_W + 1);
  localparam int VBP_LAST  = (VBP_LINES > 0) ? VBP_LINES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [LW-1:0]   line_cnt;
  logic [BPW-1:0]  bar_pos;
  logic [2:0]      bar_idx;
  logic [BITS-1:0] frame_cnt;
  logic [1:0]      pat_q;
  logic [BITS-1:0] solid_r_q;
  logic [BITS-1:0] solid_g_q;
  logic [BITS-1:0] solid_b_q;

  logic            line_end;
  logic            last_line;
  logic            href_nxt;
  logic            vsync_nxt;
  logic            done_nxt;
  logic [BITS-1:0] x;
  logic [BITS-1:0] y;
  logic [BITS-1:0] r_nxt;
  logic [BITS-1:0] g_nxt;
  logic [BITS-1:0] b_nxt;

  assign line_end = (h_cnt == HW'(LINE_LEN - 1));

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    last_line = 1'b0;
    case (state)
      S_VSYNC:  last_line = (line_cnt == LW'(VS_LINES - 1));
      S_VBP:    last_line = (line_cnt == LW'(VBP_LAST));
      S_ACTIVE: last_line = (line_cnt == LW'(HEIGHT - 1));
      S_VFP:    last_line = (line_cnt == LW'(VFP_LINES - 1));
      default:  last_line = 1'b0;
    endcase
  end

  // Next-cycle output values, derived from the current counters and registered below.
  always_comb begin
    x         = BITS'(h_cnt);
    y         = BITS'(line_cnt);
    href_nxt  = (state == S_ACTIVE) && (h_cnt < HW'(WIDTH));
    vsync_nxt = (state == S_VSYNC);
    done_nxt  = (state == S_VFP) && last_line && line_end;
    r_nxt     = '0;
    g_nxt     = '0;
    b_nxt     = '0;
    if (href_nxt) begin
      case (pat_q)
        2'd0: begin
          // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
          r_nxt = {BITS{~bar_idx[1]}};
          g_nxt = {BITS{~bar_idx[2]}};
          b_nxt = {BITS{~bar_idx[0]}};
        end
        2'd1: begin
          r_nxt = x;
          g_nxt = x;
          b_nxt = x;
        end
        2'd2: begin
          r_nxt = solid_r_q;
          g_nxt = solid_g_q;
          b_nxt = solid_b_q;
        end
        default: begin
          r_nxt = x + frame_cnt;
          g_nxt = y + frame_cnt;
          b_nxt = x ^ y;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= S_IDLE;
      h_cnt      <= '0;
      line_cnt   <= '0;
      bar_pos    <= '0;
      bar_idx    <= '0;
      frame_cnt  <= '0;
      pat_q      <= '0;
      solid_r_q  <= '0;
      solid_g_q  <= '0;
      solid_b_q  <= '0;
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      out_href   <= href_nxt;
      out_vsync  <= vsync_nxt;
      out_r      <= r_nxt;
      out_g      <= g_nxt;
      out_b      <= b_nxt;
      frame_done <= done_nxt;

      if (state == S_IDLE) begin
        h_cnt    <= '0;
        line_cnt <= '0;
        bar_pos  <= '0;
        bar_idx  <= '0;
        if (enable) begin
          state     <= S_VSYNC;
          pat_q     <= pattern_sel;
          solid_r_q <= solid_r;
          solid_g_q <= solid_g;
          solid_b_q <= solid_b;
        end
      end else begin
        if (line_end) begin
          h_cnt   <= '0;
          bar_pos <= '0;
          bar_idx <= '0;
        end else begin
          h_cnt <= h_cnt + HW'(1);
          if (bar_pos == BPW'(BAR_W - 1)) begin
            bar_pos <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_pos <= bar_pos + BPW'(1);
          end
        end

        if (line_end) begin
          if (last_line) begin
            line_cnt <= '0;
            case (state)
              S_VSYNC:  state <= (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
              S_VBP:    state <= S_ACTIVE;
              S_ACTIVE: state <= S_VFP;
              S_VFP: begin
                frame_cnt <= frame_cnt + BITS'(1);
                if (enable) begin
                  state     <= S_VSYNC;
                  pat_q     <= pattern_sel;
                  solid_r_q <= solid_r;
                  solid_g_q <= solid_g;
                  solid_b_q <= solid_b;
                end else begin
                  state <= S_IDLE;
                end
              end
              default:  state <= S_IDLE;
            endcase
          end else begin
            line_cnt <= line_cnt + LW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_isp_pattern_gen.sv
// Directed bench for isp_pattern_gen: expected per-cycle outputs are queued as
// stimulus is applied and popped against the DUT on each falling clock edge.
module tb_isp_pattern_gen;

  localparam int BITS      = 8;
  localparam int WIDTH     = 16;
  localparam int HEIGHT    = 4;
  localparam int HBLANK    = 4;
  localparam int VS_LINES  = 1;
  localparam int VBP_LINES = 1;
  localparam int VFP_LINES = 1;
  localparam int LINE_LEN  = WIDTH + HBLANK;
  localparam int FRAME_LEN = LINE_LEN * (VS_LINES + VBP_LINES + HEIGHT + VFP_LINES);
  localparam int ACT_FIRST = VS_LINES + VBP_LINES;

  logic            pclk;
  logic            rst;
  logic            enable;
  logic [1:0]      pattern_sel;
  logic [BITS-1:0] solid_r;
  logic [BITS-1:0] solid_g;
  logic [BITS-1:0] solid_b;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_r;
  logic [BITS-1:0] out_g;
  logic [BITS-1:0] out_b;
  logic            frame_done;

  typedef struct packed {
    logic            vs;
    logic            href;
    logic            done;
    logic [BITS-1:0] r;
    logic [BITS-1:0] g;
    logic [BITS-1:0] b;
  } px_t;

  px_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  isp_pattern_gen #(
    .BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .HBLANK(HBLANK),
    .VS_LINES(VS_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .out_href(out_href), .out_vsync(out_vsync),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .frame_done(frame_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_idle(input int n);
    px_t z;
    z = '0;
    repeat (n) sb_q.push_back(z);
  endtask

  // Builds the expected output of the first n_pos cycles of one frame.
  task automatic push_frame(input int pat, input logic [BITS-1:0] sr, input logic [BITS-1:0] sg,
                            input logic [BITS-1:0] sbl, input logic [BITS-1:0] f, input int n_pos);
    for (int p = 0; p < n_pos; p++) begin
      int  line;
      int  h;
      int  yy;
      int  bar;
      px_t e;
      line   = p / LINE_LEN;
      h      = p % LINE_LEN;
      e      = '0;
      e.vs   = (line < VS_LINES);
      e.done = (p == FRAME_LEN - 1);
      if (line >= ACT_FIRST && line < ACT_FIRST + HEIGHT && h < WIDTH) begin
        yy     = line - ACT_FIRST;
        e.href = 1'b1;
        case (pat)
          0: begin
            bar = h / (WIDTH / 8);
            e.r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? '1 : '0;
            e.g = (bar <= 3) ? '1 : '0;
            e.b = (bar == 0 || bar == 2 || bar == 4 || bar == 6) ? '1 : '0;
          end
          1: begin
            e.r = BITS'(h);
            e.g = BITS'(h);
            e.b = BITS'(h);
          end
          2: begin
            e.r = sr;
            e.g = sg;
            e.b = sbl;
          end
          default: begin
            e.r = BITS'(h + int'(f));
            e.g = BITS'(yy + int'(f));
            e.b = BITS'(h) ^ BITS'(yy);
          end
        endcase
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic expect_cycles(input int n);
    px_t e;
    repeat (n) begin
      @(negedge pclk);
      cyc++;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL scoreboard_empty cyc=%0d observed=0 expected=1", cyc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("vsync", BITS'(out_vsync), BITS'(e.vs));
        check("href", BITS'(out_href), BITS'(e.href));
        check("frame_done", BITS'(frame_done), BITS'(e.done));
        check("red", out_r, e.r);
        check("green", out_g, e.g);
        check("blue", out_b, e.b);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 1'b1;
    pattern_sel = 2'd0;
    solid_r     = '0;
    solid_g     = '0;
    solid_b     = '0;

    // Reset held three cycles with enable high: everything stays 0.
    push_idle(3);
    expect_cycles(3);
    rst = 1'b0;

    // One cycle to leave IDLE, then frame 0 with colour bars.
    push_idle(1);
    push_frame(0, '0, '0, '0, 8'd0, FRAME_LEN);
    expect_cycles(1 + 60);
    pattern_sel = 2'd3;

    // Frame 1 takes the moving ramp with F=1.
    push_frame(3, '0, '0, '0, 8'd1, FRAME_LEN);
    expect_cycles(FRAME_LEN);
    pattern_sel = 2'd0;

    // Frame 2 is bars; solid selected mid-ACTIVE only affects frame 3.
    push_frame(0, '0, '0, '0, 8'd2, FRAME_LEN);
    expect_cycles(FRAME_LEN);
    pattern_sel = 2'd2;
    solid_r     = 8'h12;
    solid_g     = 8'h34;
    solid_b     = 8'h56;
    push_frame(2, 8'h12, 8'h34, 8'h56, 8'd3, FRAME_LEN);
    expect_cycles(FRAME_LEN);

    // Enable dropped mid-ACTIVE: frame 3 completes, then idle.
    enable  = 1'b0;
    solid_r = 8'hAA;
    push_idle(6);
    expect_cycles(FRAME_LEN - 60 + 5);

    // Restart after one idle cycle with the ramp, F=4; reset at x=8 of active line 1.
    pattern_sel = 2'd3;
    enable      = 1'b1;
    push_frame(3, '0, '0, '0, 8'd4, (ACT_FIRST + 1) * LINE_LEN + 9);
    expect_cycles(1 + (ACT_FIRST + 1) * LINE_LEN + 9);
    rst = 1'b1;
    push_idle(2);
    push_frame(3, '0, '0, '0, 8'd0, FRAME_LEN);
    expect_cycles(1);
    rst = 1'b0;
    expect_cycles(1 + FRAME_LEN);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
